uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path (TX FIFO feeding the transmitter) between NUM_REQ byte-stream requesters.
- Grants one requester at a time, round-robin, for a burst that ends on last-flag, burst limit or requester stall.
- Writes accepted bytes into the TX FIFO write port and honours fifo full.
- Sits between client logic and the UART top-level TX FIFO, in the clk_main domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 8, maximum bytes per grant (1..255).
- GW, derived, max(1, $clog2(NUM_REQ)), width of grant index.
- CW, derived, $clog2(MAX_BURST+1), width of burst counter.

Ports:
- clk_main  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of requester's burst.
- req_ready  out  NUM_REQ  byte accepted this cycle when req_valid&req_ready.
- fifo_wr_en  out  1  TX FIFO write strobe.
- fifo_wr_data  out  8  TX FIFO write data.
- fifo_full  in  1  TX FIFO full.
- grant_id  out  GW  index of current or last grantee.
- grant_active  out  1  high in any non-IDLE state.
- burst_cnt  out  CW  bytes written in the current burst.

Behaviour:
- Reset values: state=IDLE, grant_id=0, rr_ptr=NUM_REQ-1, burst_cnt=0, grant_active=0, req_ready=0, fifo_wr_en=0, fifo_wr_data=0.
- Reset mid-burst aborts immediately. No write is issued after reset asserts. A partial burst is not resumed.
- States: IDLE, XFER, plus HDR when the optional feature is enabled.
- IDLE:
  - If any req_valid is high, select the first set bit searching rr_ptr+1, rr_ptr+2, ... with modulo NUM_REQ wrap.
  - Register it into grant_id, clear burst_cnt, then go to XFER (or HDR).
  - No byte is accepted in IDLE. Latency is 1 cycle from request to grant.
- XFER:
  - req_ready[grant_id] = req_valid[grant_id] & ~fifo_full. All other req_ready bits are 0.
  - Combinational: fifo_wr_en = req_valid[g] & req_ready[g]; fifo_wr_data = req_data[g].
  - On each write, burst_cnt increments.
- Burst termination, evaluated in XFER:
  - a) write with req_last=1;
  - b) write that brings burst_cnt to MAX_BURST;
  - c) req_valid[g]=0 with fifo_full=0 (requester stalled).
  - On any of these, go to IDLE next cycle and set rr_ptr=grant_id.
  - fifo_full alone never ends a burst; the arbiter waits indefinitely.
- Simultaneous requests: round-robin order only. The just-served requester has lowest priority next arbitration.
- A single request is re-granted after one IDLE cycle.
- Minimum gap between bursts is 1 cycle (the IDLE cycle).
- grant_id holds its value in IDLE until the next grant.
- Requests arriving during a burst wait. They are never dropped.
- fifo_wr_en is never asserted while fifo_full=1.

Optional Feature:
- Macro UART_ARB_HDR_EN.
- Defined:
  - After grant, the HDR state writes header byte 8'hA0 | grant_id, zero-extended, when fifo_full=0, then goes to XFER.
  - req_ready is 0 in HDR.
  - The header does not count toward burst_cnt or MAX_BURST.
  - HDR waits while fifo_full=1.
- Undefined: no HDR state; the grant goes straight to XFER and the stream carries only payload bytes.

Test Plan:
- Single requester 1 sends bytes 8'hD3, 8'hF0 with last on 8'hF0 -> grant_id=1 one cycle after valid; FIFO receives D3, F0 on consecutive cycles; back to IDLE; burst_cnt=2.
- Requesters 0, 2, 3 valid continuously with 1-byte bursts (last=1) -> grant order 0, 2, 3, 0, 2, 3; no writes in IDLE cycles.
- Requester 0 streams 20 bytes, no last, MAX_BURST=8 -> bursts of 8, 8, 4. With requester 1 also valid, order 0, 1, 0, 1, ...
- fifo_full asserted for 5 cycles mid-burst -> fifo_wr_en=0 and req_ready=0 for those cycles; burst resumes with no byte lost or duplicated.
- reset driven low mid-burst after 3 bytes -> all outputs at reset values asynchronously; after release, fresh arbitration starts from requester 0.
- With UART_ARB_HDR_EN, requester 2 sends 8'h55 (last) -> FIFO receives A2, 55.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port between NUM_REQ byte streams.
// Optional header byte per grant enabled by defining UART_ARB_HDR_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  parameter int GW        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  parameter int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk_main,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 fifo_wr_en,
  output logic [7:0]           fifo_wr_data,
  input  logic                 fifo_full,
  output logic [GW-1:0]        grant_id,
  output logic                 grant_active,
  output logic [CW-1:0]        burst_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
`ifdef UART_ARB_HDR_EN
  localparam logic [1:0] S_HDR  = 2'd2;
`endif

  logic [1:0]    state;
  logic [GW-1:0] rr_ptr;

  logic [7:0]    data_arr [NUM_REQ];
  logic          g_valid;
  logic          g_last;
  logic [7:0]    g_data;
  logic          xfer_wr;
  logic [CW-1:0] burst_cnt_nxt;
  logic          burst_end;

  logic          arb_found;
  logic [GW-1:0] arb_idx;
  logic [31:0]   idx_wide;
  logic [GW-1:0] cand;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[8*i +: 8];
    end
  end

  assign g_valid = req_valid[grant_id];
  assign g_last  = req_last[grant_id];
  assign g_data  = data_arr[grant_id];

  // Search starts one past the last grantee so it ends up with lowest priority.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    idx_wide  = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx_wide = (32'(rr_ptr) + 32'(i)) % 32'(NUM_REQ);
      cand     = idx_wide[GW-1:0];
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    case (state)
      S_XFER: begin
        req_ready[grant_id] = g_valid & ~fifo_full;
        fifo_wr_en          = g_valid & ~fifo_full;
        fifo_wr_data        = g_data;
      end
`ifdef UART_ARB_HDR_EN
      S_HDR: begin
        fifo_wr_en   = ~fifo_full;
        fifo_wr_data = 8'hA0 | 8'(grant_id);
      end
`endif
      default: ;
    endcase
  end

  assign xfer_wr       = (state == S_XFER) & g_valid & ~fifo_full;
  assign burst_cnt_nxt = burst_cnt + CW'(1);
  // A stall only ends the burst when the FIFO could have taken a byte.
  assign burst_end     = (xfer_wr & (g_last | (burst_cnt_nxt == CW'(MAX_BURST)))) |
                         (~g_valid & ~fifo_full);
  assign grant_active  = (state != S_IDLE);

  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      grant_id  <= '0;
      rr_ptr    <= GW'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_found) begin
            grant_id  <= arb_idx;
            burst_cnt <= '0;
`ifdef UART_ARB_HDR_EN
            state     <= S_HDR;
`else
            state     <= S_XFER;
`endif
          end
        end
`ifdef UART_ARB_HDR_EN
        S_HDR: begin
          if (!fifo_full) state <= S_XFER;
        end
`endif
        S_XFER: begin
          if (xfer_wr) burst_cnt <= burst_cnt_nxt;
          if (burst_end) begin
            state  <= S_IDLE;
            rr_ptr <= grant_id;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter; define UART_ARB_HDR_EN to expect header bytes.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 8;
  localparam int GW        = 2;
  localparam int CW        = 4;

  logic                 clk_main = 1'b0;
  logic                 reset    = 1'b0;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 fifo_wr_en;
  logic [7:0]           fifo_wr_data;
  logic                 fifo_full = 1'b0;
  logic [GW-1:0]        grant_id;
  logic                 grant_active;
  logic [CW-1:0]        burst_cnt;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
    .clk_main(clk_main), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .grant_id(grant_id), .grant_active(grant_active), .burst_cnt(burst_cnt)
  );

  always #5 clk_main = ~clk_main;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  logic [8:0] src_q [NUM_REQ][$];
  logic [9:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_src(input int id, input logic [7:0] d, input logic last);
    src_q[id].push_back({last, d});
  endtask

  task automatic push_exp(input int id, input logic [7:0] d);
    exp_q.push_back({2'(id), d});
  endtask

  task automatic push_hdr(input int id);
`ifdef UART_ARB_HDR_EN
    push_exp(id, 8'hA0 | 8'(id));
`endif
  endtask

  function automatic bit src_pending();
    for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_drain(input string tag);
    int cyc = 0;
    while ((exp_q.size() != 0 || src_pending() || grant_active) && cyc < 400) begin
      @(negedge clk_main); #1;
      cyc++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    check({tag, "_drain_time"}, (cyc < 400), 1);
    @(posedge clk_main); #1;
  endtask

  task automatic wait_writes(input string tag, input int target);
    int cyc = 0;
    while (wr_count < target && cyc < 200) begin
      @(negedge clk_main); #1;
      cyc++;
    end
    check({tag, "_writes"}, (wr_count >= target), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_grant_active"}, grant_active, 0);
    check({tag, "_burst_cnt"}, burst_cnt, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_wr_en"}, fifo_wr_en, 0);
    check({tag, "_wr_data"}, fifo_wr_data, 0);
  endtask

  // Scoreboard monitor: every FIFO write must match the next expected {grant_id, byte}.
  always @(negedge clk_main) begin
    if (reset && fifo_wr_en) begin
      wr_count++;
      check("wr_while_full", fifo_full, 0);
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: observed %0h expected none", {grant_id, fifo_wr_data});
      end
      if (exp_q.size() != 0) check("fifo_write", {grant_id, fifo_wr_data}, exp_q.pop_front());
    end
  end

  // Requester model: presents the head of each source queue, pops it on handshake.
  initial begin
    logic [NUM_REQ-1:0] fire;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk_main);
      fire = req_valid & req_ready;
      @(posedge clk_main); #1;
      for (int i = 0; i < NUM_REQ; i++)
        if (fire[i] && reset && src_q[i].size() != 0) void'(src_q[i].pop_front());
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (src_q[i].size() != 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = src_q[i][0][7:0];
          req_last[i]        = src_q[i][0][8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(posedge clk_main);
    #1;
    check_reset_outputs("por");
    reset = 1'b1;
    @(posedge clk_main); #1;

    // Round robin with 1-byte bursts from 0, 2, 3
    push_src(0, 8'h01, 1'b1); push_src(0, 8'h02, 1'b1);
    push_src(2, 8'h21, 1'b1); push_src(2, 8'h22, 1'b1);
    push_src(3, 8'h31, 1'b1); push_src(3, 8'h32, 1'b1);
    push_hdr(0); push_exp(0, 8'h01);
    push_hdr(2); push_exp(2, 8'h21);
    push_hdr(3); push_exp(3, 8'h31);
    push_hdr(0); push_exp(0, 8'h02);
    push_hdr(2); push_exp(2, 8'h22);
    push_hdr(3); push_exp(3, 8'h32);
    wait_drain("rr");
    check("rr_grant_id", grant_id, 3);
    check("rr_burst_cnt", burst_cnt, 1);

    // Single requester 1: D3, F0(last)
    push_src(1, 8'hD3, 1'b0); push_src(1, 8'hF0, 1'b1);
    push_hdr(1); push_exp(1, 8'hD3); push_exp(1, 8'hF0);
    @(negedge clk_main);
    check("single_idle_active", grant_active, 0);
    check("single_idle_wr", fifo_wr_en, 0);
    @(negedge clk_main);
    check("single_grant_id", grant_id, 1);
    check("single_grant_active", grant_active, 1);
    wait_drain("single");
    check("single_burst_cnt", burst_cnt, 2);
    check("single_grant_hold", grant_id, 1);

    // Burst limit: requester 0 20 bytes, requester 1 10 bytes, no last flags
    for (int k = 0; k < 20; k++) push_src(0, 8'(k), 1'b0);
    for (int k = 0; k < 10; k++) push_src(1, 8'(8'h80 + k), 1'b0);
    push_hdr(0); for (int k = 0;  k < 8;  k++) push_exp(0, 8'(k));
    push_hdr(1); for (int k = 0;  k < 8;  k++) push_exp(1, 8'(8'h80 + k));
    push_hdr(0); for (int k = 8;  k < 16; k++) push_exp(0, 8'(k));
    push_hdr(1); for (int k = 8;  k < 10; k++) push_exp(1, 8'(8'h80 + k));
    push_hdr(0); for (int k = 16; k < 20; k++) push_exp(0, 8'(k));
    wait_drain("limit");
    check("limit_burst_cnt", burst_cnt, 4);
    check("limit_grant_id", grant_id, 0);

    // FIFO full for 5 cycles mid-burst
    for (int k = 0; k < 6; k++) push_src(2, 8'(8'hC0 + k), (k == 5));
    push_hdr(2); for (int k = 0; k < 6; k++) push_exp(2, 8'(8'hC0 + k));
    base = wr_count;
    wait_writes("full", base + 2);
    @(posedge clk_main); #1;
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_main);
      check("full_wr_en", fifo_wr_en, 0);
      check("full_req_ready", req_ready, 0);
      check("full_active", grant_active, 1);
    end
    @(posedge clk_main); #1;
    fifo_full = 1'b0;
    wait_drain("full");
    check("full_burst_cnt", burst_cnt, 6);

    // Asynchronous reset after 3 writes of a burst
    for (int k = 0; k < 10; k++) push_src(3, 8'(8'hE0 + k), 1'b0);
    push_hdr(3); for (int k = 0; k < 10; k++) push_exp(3, 8'(8'hE0 + k));
    base = wr_count;
    wait_writes("rst", base + 3);
    @(posedge clk_main); #3;
    reset = 1'b0;
    src_q[3].delete();
    #1;
    check_reset_outputs("midrst");
`ifdef UART_ARB_HDR_EN
    check("midrst_unwritten", exp_q.size(), 8);
`else
    check("midrst_unwritten", exp_q.size(), 7);
`endif
    exp_q.delete();
    @(posedge clk_main); #1;
    reset = 1'b1;
    push_src(0, 8'h11, 1'b1); push_src(2, 8'h2A, 1'b1);
    push_hdr(0); push_exp(0, 8'h11);
    push_hdr(2); push_exp(2, 8'h2A);
    wait_drain("postrst");
    check("postrst_grant_id", grant_id, 2);

    // Requester 2 single byte 55 (header A2 when enabled)
    push_src(2, 8'h55, 1'b1);
    push_hdr(2); push_exp(2, 8'h55);
    wait_drain("hdr");
    check("hdr_burst_cnt", burst_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
